// File: rtl/management_register_file_if.sv
// rtl/management_register_file_if.sv - byte-wide management bridge read/write bus
// The bridge drives strobes, addresses and write data; the register file returns read data.
interface management_register_file_if;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_valid, rd_data
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/management_register_file.sv
// rtl/management_register_file.sv - byte-addressed management registers
// ID, sticky IRQ status/enable, uptime with snapshot, shadowed CTRL commit and scratch bytes.
module management_register_file #(
   parameter logic [31:0] DEVICE_ID = 32'h4C50_0001
) (
   input  logic                               clk,
   input  logic                               rst_n,
   management_register_file_if.slave          bus,
   input  logic [7:0]                         irq_event,
   output logic                               irq,
   output logic [31:0]                        ctrl_out,
   output logic                               ctrl_commit
);

   localparam logic [15:0] ADDR_ID0        = 16'h0000;
   localparam logic [15:0] ADDR_ID1        = 16'h0001;
   localparam logic [15:0] ADDR_ID2        = 16'h0002;
   localparam logic [15:0] ADDR_ID3        = 16'h0003;
   localparam logic [15:0] ADDR_IRQ_STATUS = 16'h0004;
   localparam logic [15:0] ADDR_IRQ_ENABLE = 16'h0005;
   localparam logic [15:0] ADDR_UPTIME0    = 16'h0008;
   localparam logic [15:0] ADDR_UPTIME1    = 16'h0009;
   localparam logic [15:0] ADDR_UPTIME2    = 16'h000A;
   localparam logic [15:0] ADDR_UPTIME3    = 16'h000B;
   localparam logic [15:0] ADDR_CTRL0      = 16'h0010;
   localparam logic [15:0] ADDR_CTRL1      = 16'h0011;
   localparam logic [15:0] ADDR_CTRL2      = 16'h0012;
   localparam logic [15:0] ADDR_CTRL3      = 16'h0013;
   localparam logic [11:0] SCRATCH_PAGE    = 12'h002;

   logic [7:0]  irq_status;
   logic [7:0]  irq_enable;
   logic [31:0] uptime;
   logic [31:0] snapshot;
   logic [31:0] shadow;
   logic [7:0]  scratch [16];

   logic [7:0]  read_byte;
   logic        rd_hit_uptime0;
   logic        rd_hit_scratch;
   logic        wr_hit_scratch;
   logic        wr_hit_status;
   logic        wr_hit_enable;
   logic        wr_hit_ctrl3;
   logic [7:0]  w1c_mask;

   assign rd_hit_uptime0 = bus.rd_en && (bus.rd_addr == ADDR_UPTIME0);
   assign rd_hit_scratch = (bus.rd_addr[15:4] == SCRATCH_PAGE);
   assign wr_hit_scratch = bus.wr_en && (bus.wr_addr[15:4] == SCRATCH_PAGE);
   assign wr_hit_status  = bus.wr_en && (bus.wr_addr == ADDR_IRQ_STATUS);
   assign wr_hit_enable  = bus.wr_en && (bus.wr_addr == ADDR_IRQ_ENABLE);
   assign wr_hit_ctrl3   = bus.wr_en && (bus.wr_addr == ADDR_CTRL3);
   assign w1c_mask       = wr_hit_status ? bus.wr_data : 8'h00;

   // Read mux sees pre-write state, so a same-cycle write to the read address is not visible.
   always_comb begin
      read_byte = 8'h00;
      case (bus.rd_addr)
         ADDR_ID0:        read_byte = DEVICE_ID[7:0];
         ADDR_ID1:        read_byte = DEVICE_ID[15:8];
         ADDR_ID2:        read_byte = DEVICE_ID[23:16];
         ADDR_ID3:        read_byte = DEVICE_ID[31:24];
         ADDR_IRQ_STATUS: read_byte = irq_status;
         ADDR_IRQ_ENABLE: read_byte = irq_enable;
         ADDR_UPTIME0:    read_byte = uptime[7:0];
         ADDR_UPTIME1:    read_byte = snapshot[15:8];
         ADDR_UPTIME2:    read_byte = snapshot[23:16];
         ADDR_UPTIME3:    read_byte = snapshot[31:24];
         ADDR_CTRL0:      read_byte = shadow[7:0];
         ADDR_CTRL1:      read_byte = shadow[15:8];
         ADDR_CTRL2:      read_byte = shadow[23:16];
         ADDR_CTRL3:      read_byte = shadow[31:24];
         default: begin
            if (rd_hit_scratch) begin
               read_byte = scratch[bus.rd_addr[3:0]];
            end
         end
      endcase
   end

   // An in-flight read is lost on reset because rd_valid is cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= 8'h00;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= read_byte;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uptime   <= 32'h0000_0000;
         snapshot <= 32'h0000_0000;
      end else begin
         uptime <= uptime + 32'd1;
         if (rd_hit_uptime0) begin
            snapshot <= uptime;
         end
      end
   end

   // Event set is OR-ed in after the W1C mask so a coincident event wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_status <= 8'h00;
         irq_enable <= 8'h00;
         irq        <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~w1c_mask) | irq_event;
         if (wr_hit_enable) begin
            irq_enable <= bus.wr_data;
         end
         irq <= |(irq_status & irq_enable);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= 32'h0000_0000;
      end else if (bus.wr_en) begin
         case (bus.wr_addr)
            ADDR_CTRL0: shadow[7:0]   <= bus.wr_data;
            ADDR_CTRL1: shadow[15:8]  <= bus.wr_data;
            ADDR_CTRL2: shadow[23:16] <= bus.wr_data;
            ADDR_CTRL3: shadow[31:24] <= bus.wr_data;
            default:    shadow        <= shadow;
         endcase
      end
   end

   // The commit uses the incoming top byte directly since shadow is not yet updated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_out    <= 32'h0000_0000;
         ctrl_commit <= 1'b0;
      end else begin
         ctrl_commit <= wr_hit_ctrl3;
         if (wr_hit_ctrl3) begin
            ctrl_out <= {bus.wr_data, shadow[23:0]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            scratch[i] <= 8'h00;
         end
      end else if (wr_hit_scratch) begin
         scratch[bus.wr_addr[3:0]] <= bus.wr_data;
      end
   end

endmodule

// File: tb/tb_management_register_file.sv
// tb/tb_management_register_file.sv - directed table and sequence checks for management_register_file
module tb_management_register_file;

   logic        clk;
   logic        rst_n;
   logic [7:0]  irq_event;
   logic        irq;
   logic [31:0] ctrl_out;
   logic        ctrl_commit;
   logic [31:0] m;

   int tests;
   int fails;

   management_register_file_if bus ();

   management_register_file dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .irq_event   (irq_event),
      .irq         (irq),
      .ctrl_out    (ctrl_out),
      .ctrl_commit (ctrl_commit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference uptime counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= 32'h0;
      else        m <= m + 32'd1;
   end

   typedef struct {
      logic        is_write;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = addr;
      bus.wr_data = data;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic read_check(input logic [15:0] addr, input logic [7:0] exp, input string name);
      @(negedge clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = addr;
      @(negedge clk);
      bus.rd_en   = 1'b0;
      check({name, "_valid"}, {31'h0, bus.rd_valid}, 32'h1);
      check({name, "_data"}, {24'h0, bus.rd_data}, {24'h0, exp});
   endtask

   task automatic pulse_event(input logic [7:0] ev);
      @(negedge clk);
      irq_event = ev;
      @(negedge clk);
      irq_event = 8'h00;
   endtask

   logic [31:0] snap;
   logic [7:0]  id_exp [4];

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      irq_event   = 8'h00;
      bus.rd_en   = 1'b0;
      bus.rd_addr = 16'h0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = 16'h0;
      bus.wr_data = 8'h0;

      vecs[0]  = '{1'b1, 16'h0000, 8'hFF};
      vecs[1]  = '{1'b0, 16'h0000, 8'h01};
      vecs[2]  = '{1'b1, 16'h0020, 8'h12};
      vecs[3]  = '{1'b1, 16'h002F, 8'h5A};
      vecs[4]  = '{1'b0, 16'h002F, 8'h5A};
      vecs[5]  = '{1'b0, 16'h0020, 8'h12};
      vecs[6]  = '{1'b0, 16'h0030, 8'h00};
      vecs[7]  = '{1'b1, 16'h1020, 8'h77};
      vecs[8]  = '{1'b0, 16'h0020, 8'h12};
      vecs[9]  = '{1'b0, 16'h1020, 8'h00};
      vecs[10] = '{1'b1, 16'h0005, 8'hA5};
      vecs[11] = '{1'b0, 16'h0005, 8'hA5};
      vecs[12] = '{1'b1, 16'h0005, 8'h00};
      vecs[13] = '{1'b0, 16'h0005, 8'h00};
      vecs[14] = '{1'b0, 16'h0004, 8'h00};
      vecs[15] = '{1'b0, 16'h0006, 8'h00};
      vecs[16] = '{1'b0, 16'h0014, 8'h00};
      vecs[17] = '{1'b0, 16'hFFFF, 8'h00};
      vecs[18] = '{1'b1, 16'h0028, 8'h3C};
      vecs[19] = '{1'b0, 16'h0028, 8'h3C};

      id_exp[0] = 8'h01;
      id_exp[1] = 8'h00;
      id_exp[2] = 8'h50;
      id_exp[3] = 8'h4C;

      repeat (3) @(negedge clk);
      check("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      check("rst_rd_data", {24'h0, bus.rd_data}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_ctrl_out", ctrl_out, 32'h0);
      check("rst_ctrl_commit", {31'h0, ctrl_commit}, 32'h0);
      rst_n = 1'b1;

      // ID bytes read back-to-back
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("id_b2b%0d_valid", i - 1), {31'h0, bus.rd_valid}, 32'h1);
            check($sformatf("id_b2b%0d_data", i - 1), {24'h0, bus.rd_data}, {24'h0, id_exp[i-1]});
         end
         bus.rd_en   = 1'b1;
         bus.rd_addr = 16'(i);
      end
      @(negedge clk);
      bus.rd_en = 1'b0;
      check("id_b2b3_valid", {31'h0, bus.rd_valid}, 32'h1);
      check("id_b2b3_data", {24'h0, bus.rd_data}, {24'h0, id_exp[3]});
      @(negedge clk);
      check("id_b2b_idle", {31'h0, bus.rd_valid}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].is_write) do_write(vecs[i].addr, vecs[i].data);
         else read_check(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      end

      // Same-cycle read and write to one address
      @(negedge clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 16'h0020;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 16'h0020;
      bus.wr_data = 8'h99;
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      check("rdwr_old", {24'h0, bus.rd_data}, 32'h12);
      read_check(16'h0020, 8'h99, "rdwr_new");
      @(negedge clk);
      check("hold_valid", {31'h0, bus.rd_valid}, 32'h0);
      check("hold_data", {24'h0, bus.rd_data}, 32'h99);

      // CTRL shadow and commit
      do_write(16'h0010, 8'hAA);
      check("ctrl_b0_out", ctrl_out, 32'h0);
      check("ctrl_b0_commit", {31'h0, ctrl_commit}, 32'h0);
      do_write(16'h0011, 8'hBB);
      check("ctrl_b1_commit", {31'h0, ctrl_commit}, 32'h0);
      do_write(16'h0012, 8'hCC);
      check("ctrl_b2_out", ctrl_out, 32'h0);
      check("ctrl_b2_commit", {31'h0, ctrl_commit}, 32'h0);
      do_write(16'h0013, 8'hDD);
      check("ctrl_commit_pulse", {31'h0, ctrl_commit}, 32'h1);
      check("ctrl_out_word", ctrl_out, 32'hDDCCBBAA);
      @(negedge clk);
      check("ctrl_commit_end", {31'h0, ctrl_commit}, 32'h0);
      do_write(16'h0010, 8'h11);
      check("ctrl_out_kept", ctrl_out, 32'hDDCCBBAA);
      read_check(16'h0010, 8'h11, "ctrl_shadow_rd");
      read_check(16'h0013, 8'hDD, "ctrl_shadow_rd3");

      // IRQ status, enable, W1C and lag
      pulse_event(8'h04);
      read_check(16'h0004, 8'h04, "irq_status_set");
      read_check(16'h0004, 8'h04, "irq_status_noclr");
      check("irq_disabled", {31'h0, irq}, 32'h0);
      do_write(16'h0005, 8'h04);
      check("irq_lag", {31'h0, irq}, 32'h0);
      @(negedge clk);
      check("irq_asserted", {31'h0, irq}, 32'h1);
      do_write(16'h0004, 8'h04);
      @(negedge clk);
      check("irq_cleared", {31'h0, irq}, 32'h0);
      read_check(16'h0004, 8'h00, "irq_status_w1c");

      pulse_event(8'h01);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 16'h0004;
      bus.wr_data = 8'h05;
      irq_event   = 8'h04;
      @(negedge clk);
      bus.wr_en   = 1'b0;
      irq_event   = 8'h00;
      read_check(16'h0004, 8'h04, "irq_set_wins");
      @(negedge clk);
      check("irq_set_wins_irq", {31'h0, irq}, 32'h1);

      // Uptime snapshot taken just before byte1 rolls over
      for (int k = 0; k < 300 && m[7:0] != 8'hC0; k++) @(negedge clk);
      check("uptime_align", {24'h0, m[7:0]}, 32'hC0);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 16'h0008;
      snap        = m;
      @(negedge clk);
      bus.rd_en = 1'b0;
      check("uptime_b0", {24'h0, bus.rd_data}, {24'h0, snap[7:0]});
      repeat (100) @(negedge clk);
      read_check(16'h0009, snap[15:8], "uptime_b1");
      read_check(16'h000A, snap[23:16], "uptime_b2");
      read_check(16'h000B, snap[31:24], "uptime_b3");

      // Reset during an in-flight read
      read_check(16'h002F, 8'h5A, "pre_rst_rd");
      @(negedge clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 16'h002F;
      #2 rst_n = 1'b0;
      #1;
      bus.rd_en = 1'b0;
      check("arst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      check("arst_rd_data", {24'h0, bus.rd_data}, 32'h0);
      check("arst_irq", {31'h0, irq}, 32'h0);
      check("arst_ctrl_out", ctrl_out, 32'h0);
      check("arst_ctrl_commit", {31'h0, ctrl_commit}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_dropped0", {31'h0, bus.rd_valid}, 32'h0);
      @(negedge clk);
      check("arst_dropped1", {31'h0, bus.rd_valid}, 32'h0);
      read_check(16'h002F, 8'h00, "arst_scratch");
      read_check(16'h0010, 8'h00, "arst_shadow");
      read_check(16'h0005, 8'h00, "arst_enable");
      read_check(16'h0004, 8'h00, "arst_status");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
